anim_tick_sched: RTL and testbench
==================================

Name: anim_tick_sched

Overview:
Multi-channel tick scheduler for the AnimatedColor design. It shares one 100 MHz clock between N_CH independent programmable time bases, and each channel emits a one-cycle enable pulse and a 50% square wave. A run/pause state machine sequences all channels, and a valid/ready config port reprograms periods without glitches. Color-animation stages downstream use tick_o as clock enables and never use it as a derived clock.

Parameters:
N_CH, 4, number of tick channels (2..8).
CNT_W, 27, period counter width; holds 100_000_000 (1 Hz at 100 MHz).
DEF_PERIOD, 27'd100000000, period in clk cycles loaded into every channel at reset.

Ports:
clk  in  1  system clock, 100 MHz.
rst_n  in  1  asynchronous active-low reset.
run  in  1  level; 1 = channels count, 0 = pause request.
cfg_valid  in  1  config request.
cfg_ready  out  1  config accept; transfer occurs on cfg_valid & cfg_ready at posedge clk.
cfg_ch  in  $clog2(N_CH)  target channel.
cfg_period  in  CNT_W  new period in clk cycles.
tick_o  out  N_CH  per-channel one-cycle pulse, once per period.
sq_o  out  N_CH  per-channel square wave.
active  out  1  1 while in RUN.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, all counters 0, period[i]=DEF_PERIOD, no pending shadows, tick_o=0, sq_o=0, active=0, cfg_ready=1.
- FSM has three states.
  - IDLE: counters held at 0, outputs 0. Goes to RUN when run=1.
  - RUN: active=1. Goes to PAUSE when run=0.
  - PAUSE: counters hold their value, tick_o=0, sq_o holds its last value. Goes to RUN when run=1 and resumes from the held count, with no phase loss.
  - Reset is the only path back to IDLE.
- Counting, per channel i, in RUN:
  - cnt <= (cnt == period[i]-1) ? 0 : cnt+1.
  - tick_o[i] is registered and is 1 for exactly one cycle per period, in the cycle after cnt == period[i]-1.
  - Latency from entering RUN to first tick = period[i] cycles.
  - sq_o[i] is registered: 1 while cnt < period[i]>>1, else 0. For odd periods the high phase is the shorter one.
- Period clamp: any written value below 2 is stored as 2. Period 2 gives a tick every other cycle.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch], combinational from registered state.
  - In IDLE or PAUSE, an accepted write updates period[cfg_ch] on the next edge. In PAUSE, if the held cnt >= the new period, cnt is set to 0.
  - In RUN, an accepted write goes to shadow[cfg_ch] and sets pending[cfg_ch]. The shadow is copied to period and pending clears in the wrap cycle (cnt == period-1), so the current period always completes with the old value.
  - A write to a channel with pending=1 is stalled, and the requester holds cfg_valid.
- Simultaneous events:
  - run falling in the same cycle as a wrap: the tick for that wrap is still issued and the counter goes to 0 before pausing.
  - Config accept in the same cycle as that channel's wrap: the write goes to the shadow and applies at the next wrap.
  - Config writes to different channels are independent.
- Reset mid-operation: everything returns to reset values immediately. Pending shadows are discarded and periods revert to DEF_PERIOD.
- Width: counters and comparisons are unsigned CNT_W with no overflow, since cnt < period <= 2^CNT_W-1.

Optional Feature:
PHASE_ALIGN_EN
- Defined: adds input port align (1 bit). When align=1 in RUN, every counter is set to 0 on the next edge and no tick is issued that cycle. Pending shadows apply at the same time, which phase-aligns all channels. align has priority over wrap. align is ignored in IDLE and PAUSE.
- Undefined: no align port, and channels align only at the IDLE->RUN entry.

Decomposition:
- Shared package anim_pkg:
  - CLK_HZ = 100_000_000 and CNT_W = 27.
  - State enum sched_state_t {IDLE, RUN, PAUSE}.
  - Function clamp_period().
- One sub-module, tick_chan, holds the per-channel counter, period, shadow, pending, tick and square logic. The top is the FSM, config decode and a generate loop of N_CH tick_chan instances.

Test Plan:
1. Reset, then run=1 with N_CH=4, CNT_W=8 and periods 4, 5, 2, 3 loaded in IDLE -> first ticks on ch0..3 at cycles 4, 5, 2, 3 after RUN entry, then repeating. sq_o[1] is high 2 cycles and low 3.
2. cfg_period=1 written to ch0 -> stored as 2, and tick_o[0] toggles every other cycle.
3. In RUN with ch0 period 10, write period 6 at cnt=3 -> the current period ends at 10 cycles, every later period is 6, and a second write is stalled (cfg_ready=0) until the wrap.
4. In RUN, run=0 at ch1 cnt=2 (period 5), hold 7 cycles, then run=1 -> the next tick_o[1] comes 3 cycles after resume. No ticks during PAUSE, and sq_o is held.
5. rst_n pulsed low mid-RUN with a pending write -> outputs are 0 immediately, period reverts to DEF_PERIOD, and active=0.
6. PHASE_ALIGN_EN defined: align pulse with ch0 cnt=3 and ch1 cnt=1 -> both counters are 0 next cycle, with no tick in the align cycle, and afterwards both channels tick in the same cycle wherever their periods coincide.

Source files
------------

// File: rtl/anim_pkg.sv
// Shared types and constants for the AnimatedColor tick scheduler.
// The clock rate, the default counter width, the FSM states and the period clamp live here.
package anim_pkg;

  localparam int CLK_HZ = 100_000_000;
  localparam int CNT_W  = 27;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } sched_state_t;

  // Periods of 0 or 1 cannot produce a distinct wrap, so 2 is the shortest legal period.
  function automatic logic [31:0] clamp_period(input logic [31:0] period);
    return (period < 32'd2) ? 32'd2 : period;
  endfunction

endpackage

// File: rtl/tick_chan.sv
// A single tick channel: period counter, live and shadow period, one-cycle tick and square wave.
// The scheduler FSM above this module decides when the counter runs, holds or clears.
module tick_chan
  import anim_pkg::*;
#(
  parameter int               CNT_W      = anim_pkg::CNT_W,
  parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(CLK_HZ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  sched_state_t     state,
  input  logic             alignRun,
  input  logic             wrEn,
  input  logic [CNT_W-1:0] wrPeriod,
  output logic             pending,
  output logic             tick_o,
  output logic             sq_o
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] shadow;
  logic             wrap;

  assign wrap = (cnt == period - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      period  <= DEF_PERIOD;
      // NOTE: the shadow is reset as well, so a discarded write never leaks into a later period.
      shadow  <= DEF_PERIOD;
      pending <= 1'b0;
      tick_o  <= 1'b0;
      sq_o    <= 1'b0;
    end else begin
      tick_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= '0;
          sq_o <= 1'b0;
          if (wrEn) period <= wrPeriod;
        end

        PAUSE: begin
          if (wrEn) begin
            period <= wrPeriod;
            if (cnt >= wrPeriod) cnt <= '0;
          end
        end

        RUN: begin
          sq_o <= (cnt < (period >> 1));
          if (alignRun || wrap) begin
            cnt    <= '0;
            tick_o <= !alignRun;
            if (pending) begin
              period  <= shadow;
              pending <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          // NOTE: non-blocking updates resolve last-write-wins, so a write accepted in a wrap
          // cycle re-arms pending after the clear above and lands at the following wrap.
          if (wrEn) begin
            shadow  <= wrPeriod;
            pending <= 1'b1;
          end
        end

        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/anim_tick_sched.sv
// Multi-channel tick scheduler: run/pause FSM, config decode and N_CH tick_chan instances.
// Optional build macro PHASE_ALIGN_EN adds the 'align' input that zeroes every counter in RUN.
module anim_tick_sched
  import anim_pkg::*;
#(
  parameter int               N_CH       = 4,
  parameter int               CNT_W      = anim_pkg::CNT_W,
  parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(CLK_HZ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
`ifdef PHASE_ALIGN_EN
  input  logic                    align,
`endif
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]        cfg_period,
  output logic [N_CH-1:0]         tick_o,
  output logic [N_CH-1:0]         sq_o,
  output logic                    active
);

  localparam int CH_W = $clog2(N_CH);

  sched_state_t     state;
  sched_state_t     stateNext;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  wrEn;
  logic [CNT_W-1:0] periodClamped;
  logic             alignRun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Reset is the only way back to IDLE; RUN and PAUSE alternate on the run level.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    stateNext = state;
    active    = 1'b0;
    case (state)
      IDLE:    if (run) stateNext = RUN;
      RUN: begin
        active = 1'b1;
        if (!run) stateNext = PAUSE;
      end
      PAUSE:   if (run) stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

`ifdef PHASE_ALIGN_EN
  assign alignRun = align && (state == RUN);
`else
  assign alignRun = 1'b0;
`endif

  assign periodClamped = CNT_W'(clamp_period(32'(cfg_period)));

  // Ready depends only on the addressed channel's registered pending flag.
  always_comb begin
    cfg_ready = 1'b1;
    wrEn      = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pending[i];
    end
    for (int i = 0; i < N_CH; i++) begin
      wrEn[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    tick_chan #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .state    (state),
      .alignRun (alignRun),
      .wrEn     (wrEn[i]),
      .wrPeriod (periodClamped),
      .pending  (pending[i]),
      .tick_o   (tick_o[i]),
      .sq_o     (sq_o[i])
    );
  end

endmodule

// File: tb/tb_anim_tick_sched.sv
// Directed bench for anim_tick_sched with N_CH=4, CNT_W=8 and a short default period of 20.
// Cycle k counts from the first cycle in RUN; all expected values are computed from k here.
module tb_anim_tick_sched;

  localparam int         N_CH  = 4;
  localparam int         CNT_W = 8;
  localparam logic [7:0] DEF_P = 8'd20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_period;
  logic [3:0] tick_o;
  logic [3:0] sq_o;
  logic       active;
`ifdef PHASE_ALIGN_EN
  logic       align;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int         per1 [4] = '{4, 5, 2, 3};
  logic [3:0] exp_tick;
  logic [3:0] exp_sq;

  always #5 clk = ~clk;

  anim_tick_sched #(
    .N_CH       (N_CH),
    .CNT_W      (CNT_W),
    .DEF_PERIOD (DEF_P)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
`ifdef PHASE_ALIGN_EN
    .align      (align),
`endif
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .tick_o     (tick_o),
    .sq_o       (sq_o),
    .active     (active)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    run        = 1'b0;
    cfg_valid  = 1'b0;
    cfg_ch     = 2'd0;
    cfg_period = 8'd0;
`ifdef PHASE_ALIGN_EN
    align      = 1'b0;
`endif
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [7:0] p);
    cfg_valid  = 1'b1;
    cfg_ch     = ch;
    cfg_period = p;
    step();
    cfg_valid  = 1'b0;
  endtask

  task automatic start_run();
    run = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit, expected $finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    check("reset tick_o", tick_o, 4'h0);
    check("reset sq_o", sq_o, 4'h0);
    check("reset active", active, 1'b0);
    check("reset cfg_ready", cfg_ready, 1'b1);

    // Test 1: periods 4,5,2,3 loaded in IDLE
    for (int ch = 0; ch < 4; ch++) write_cfg(2'(ch), 8'(per1[ch]));
    start_run();
    check("t1 active", active, 1'b1);
    for (int k = 0; k <= 20; k++) begin
      for (int ch = 0; ch < 4; ch++) begin
        exp_tick[ch] = (k > 0) && (k % per1[ch] == 0);
        exp_sq[ch]   = (k % per1[ch] >= 1) && (k % per1[ch] <= per1[ch] / 2);
      end
      check($sformatf("t1 tick k=%0d", k), tick_o, exp_tick);
      check($sformatf("t1 sq k=%0d", k), sq_o, exp_sq);
      step();
    end

    // Test 2: period 1 clamps to 2
    do_reset();
    write_cfg(2'd0, 8'd1);
    start_run();
    for (int k = 0; k <= 12; k++) begin
      check($sformatf("t2 tick0 k=%0d", k), tick_o[0], (k > 0) && (k % 2 == 0));
      step();
    end

    // Test 3: shadowed write in RUN and stalled second write
    do_reset();
    write_cfg(2'd0, 8'd10);
    start_run();
    for (int k = 0; k <= 30; k++) begin
      check($sformatf("t3 tick0 k=%0d", k), tick_o[0], (k == 10) || (k > 10 && (k - 10) % 6 == 0));
      check($sformatf("t3 ready k=%0d", k), cfg_ready, !((k >= 4 && k <= 9) || (k >= 11 && k <= 15)));
      if (k == 3) begin
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd0;
        cfg_period = 8'd6;
      end
      if (k == 11) cfg_valid = 1'b0;
      step();
    end

    // Test 4: pause with ch1 held at count 2, resume without phase loss
    do_reset();
    write_cfg(2'd1, 8'd5);
    start_run();
    for (int k = 0; k <= 17; k++) begin
      if (k >= 2 && k <= 8) begin
        check($sformatf("t4 pause tick k=%0d", k), tick_o, 4'h0);
        check($sformatf("t4 pause active k=%0d", k), active, 1'b0);
        check($sformatf("t4 pause sq1 k=%0d", k), sq_o[1], 1'b1);
      end
      if (k >= 9) begin
        check($sformatf("t4 tick1 k=%0d", k), tick_o[1], (k == 12) || (k == 17));
        check($sformatf("t4 sq1 k=%0d", k), sq_o[1], (k == 9) || (k == 13) || (k == 14));
      end
      if (k == 1) run = 1'b0;
      if (k == 8) run = 1'b1;
      step();
    end

    // Test 5: asynchronous reset mid-RUN with a pending write
    do_reset();
    write_cfg(2'd0, 8'd4);
    start_run();
    step();
    write_cfg(2'd0, 8'd6);
    check("t5 pending ready", cfg_ready, 1'b0);
    step();
    step();
    check("t5 tick before reset", tick_o[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5 async tick_o", tick_o, 4'h0);
    check("t5 async sq_o", sq_o, 4'h0);
    check("t5 async active", active, 1'b0);
    check("t5 async cfg_ready", cfg_ready, 1'b1);
    run = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    start_run();
    for (int k = 0; k <= 21; k++) begin
      check($sformatf("t5 default period k=%0d", k), tick_o[0], k == 20);
      step();
    end

`ifdef PHASE_ALIGN_EN
    // Test 6: align pulse at cycle 13 (ch0 count 3, ch1 count 1)
    do_reset();
    write_cfg(2'd0, 8'd5);
    write_cfg(2'd1, 8'd3);
    start_run();
    for (int k = 0; k <= 30; k++) begin
      if (k <= 13) begin
        exp_tick[0] = (k > 0) && (k % 5 == 0);
        exp_tick[1] = (k > 0) && (k % 3 == 0);
      end else begin
        exp_tick[0] = (k > 14) && ((k - 14) % 5 == 0);
        exp_tick[1] = (k > 14) && ((k - 14) % 3 == 0);
      end
      check($sformatf("t6 tick k=%0d", k), tick_o[1:0], exp_tick[1:0]);
      if (k == 13) align = 1'b1;
      if (k == 14) align = 1'b0;
      step();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
